axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- AXI3/AXI4-style responder that models a word-organised 32-bit SRAM behind the same AXI channel set the CPU core drives (ar/r/aw/w/b).
- Serves as the memory end of the bus in the SoC simulation top and in standalone CPU-interface benches.
- Handles one transaction at a time: either one read burst or one write burst.
- Supports FIXED, INCR and WRAP bursts, with byte strobes on writes.

Parameters:
- MEM_AW, 12, word-address width; memory depth = 2^MEM_AW 32-bit words.
- WRITE_FIRST, 1, when 1 a write wins over a read that arrives in the same IDLE cycle; when 0 the read wins.

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- arid  in  4  read ID
- araddr  in  32  read byte address
- arlen  in  8  read beats minus 1
- arsize  in  3  bytes per beat = 1<<arsize, max 2
- arburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rid  out  4  read data ID
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awid, awaddr, awlen, awsize, awburst, awvalid  in  4/32/8/3/2/1  write address channel, same meaning as the ar* fields
- awready  out  1  write address ready
- wid  in  4  write data ID (ignored)
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  last write beat
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bid  out  4  write response ID
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Reset: aresetn=0 forces state IDLE and clears every output (arready, awready, rvalid, rlast, wready, bvalid = 0; rid, rdata, rresp, bid, bresp = 0) immediately, without waiting for aclk.
- Reset mid-burst abandons the burst. Memory contents are preserved.
- FSM states: IDLE, RD, WR, WRESP.
- IDLE:
  - awready = awvalid & (WRITE_FIRST | ~arvalid).
  - arready = arvalid & ~awready.
  - On the handshake, capture id, addr, len, size and burst; clear the beat counter; go to RD or WR.
  - The two channels are never accepted in the same cycle.
- RD:
  - rvalid=1 starting the cycle after the AR handshake (1-cycle latency).
  - rdata = mem[addr[MEM_AW+1:2]], combinational from the current beat address.
  - rlast = (cnt==len).
  - rid = captured ID.
  - On rvalid&rready, advance the address and increment cnt. If it was the last beat, go to IDLE with rvalid=0 in the next cycle.
  - With rready held at 1, one beat is delivered per cycle.
  - rvalid and the data stay stable while rready=0.
- WR:
  - wready=1.
  - On wvalid, write the bytes of the current word selected by wstrb, then advance the address and cnt.
  - The burst ends on the beat where cnt==len, and the FSM goes to WRESP.
  - If wlast disagrees with (cnt==len) on any beat, record an error flag. The beat count alone still defines the end.
- WRESP:
  - bvalid=1, bid = captured ID, bresp = 2'b10 (SLVERR) if the error flag is set, else 00.
  - On bready, go to IDLE.
- Address advance (step = 1<<size):
  - FIXED: address unchanged.
  - INCR: addr + step, 32-bit wrap.
  - WRAP: wrap length L = (len+1)*step; next = (addr & ~(L-1)) | ((addr+step) & (L-1)).
  - A WRAP burst with len not in {1,3,7,15} is treated as INCR with response SLVERR.
- Errors:
  - Burst type 11, or size>2: the transfer still completes, with rresp=10 on every read beat or bresp=10 on the write.
  - Memory is still accessed as for INCR.
- Address range: upper address bits above MEM_AW+1 are ignored (aliasing). Bits [1:0] do not affect the word index; sub-word placement is the master's job via wstrb.
- Reads always return the full 32-bit word.

Test Plan:
- Single read: preload mem[0x10]=0xDEADBEEF; AR araddr=0x40, arlen=0, arid=3 -> one cycle later rvalid=1, rdata=0xDEADBEEF, rid=3, rlast=1, rresp=0.
- INCR read with backpressure: araddr=0x100, arlen=3, arsize=2, rready toggling 1,0,1,0… -> 4 beats returning words 0x40..0x43 in order; rlast only on beat 4; data held while rready=0.
- Strobed write: AW awaddr=0x20, awlen=0, awid=5; W wdata=0x11223344, wstrb=4'b0101 over old 0xAAAAAAAA -> bvalid, bid=5, bresp=0; a following read of 0x20 returns 0xAA22AA44.
- WRAP read: araddr=0x38, arlen=3, arburst=10 -> beat addresses 0x38, 0x3C, 0x30, 0x34.
- Write protocol error and simultaneous requests:
  - AW awlen=3 with wlast asserted on beat 2 -> 4 beats accepted; bresp=2'b10.
  - arvalid and awvalid in the same IDLE cycle with WRITE_FIRST=1 -> awready first; arready only after the B handshake.
- Reset mid-burst: drop aresetn during beat 2 of a 4-beat read -> rvalid=0 immediately; after release, a new read is served normally and memory is unchanged.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI responder backed by a word-organised 32-bit SRAM. Serves one read or
// one write burst at a time; supports FIXED/INCR/WRAP bursts and byte strobes.
module axi_sram_slave #(
  parameter int MEM_AW      = 12,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;

  logic [31:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] word_idx;
  logic [31:0] mem_rdata;
  logic        last_beat;
  logic        mem_we;
  logic        aw_take, ar_take;
  logic [3:0]  req_id;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic        wrap_bad;
  logic [31:0] addr_next;

  logic unused_wid;
  assign unused_wid = ^wid;

  function automatic logic [31:0] advance(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = ((32'(len) + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: advance = addr;
      BURST_WRAP:  advance = (addr & ~mask) | ((addr + step) & mask);
      default:     advance = addr + step;
    endcase
  endfunction

  // Upper address bits alias; bits [1:0] never select a word.
  assign word_idx  = addr_q[MEM_AW+1:2];
  assign mem_rdata = mem[word_idx];
  assign last_beat = (cnt_q == len_q);
  assign addr_next = advance(addr_q, len_q, size_q, burst_q);

  // Gated by aresetn so no handshake can be offered while reset is asserted.
  assign aw_take = aresetn && (state_q == IDLE) && awvalid && (WRITE_FIRST || !arvalid);
  assign ar_take = aresetn && (state_q == IDLE) && arvalid && !aw_take;

  assign req_id    = aw_take ? awid    : arid;
  assign req_addr  = aw_take ? awaddr  : araddr;
  assign req_len   = aw_take ? awlen   : arlen;
  assign req_size  = aw_take ? awsize  : arsize;
  assign req_burst = aw_take ? awburst : arburst;
  assign wrap_bad  = (req_burst == BURST_WRAP) && !(req_len inside {8'd1, 8'd3, 8'd7, 8'd15});

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    arready = 1'b0;
    awready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = RESP_OKAY;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = RESP_OKAY;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        awready = aw_take;
        arready = ar_take;
        if (aw_take || ar_take) begin
          id_d    = req_id;
          addr_d  = req_addr;
          len_d   = req_len;
          size_d  = req_size;
          cnt_d   = '0;
          // Illegal burst types and bad wrap lengths are served as INCR.
          burst_d = (req_burst == 2'b11 || wrap_bad) ? BURST_INCR : req_burst;
          err_d   = (req_burst == 2'b11) || (req_size > 3'd2) || wrap_bad;
          state_d = aw_take ? WR : RD;
        end
      end
      RD: begin
        rvalid = 1'b1;
        rdata  = mem_rdata;
        rlast  = last_beat;
        rid    = id_q;
        rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (rready) begin
          addr_d = addr_next;
          cnt_d  = cnt_q + 8'd1;
          if (last_beat) state_d = IDLE;
        end
      end
      WR: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we = 1'b1;
          addr_d = addr_next;
          cnt_d  = cnt_q + 8'd1;
          if (wlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the memory array has no reset; contents must survive aresetn and a
  // reset port would prevent mapping it onto an SRAM macro.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
